// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// FSM state type and op-class helpers.
package mdu_pkg;

    // MFHI/MFLO share code 7 and are told apart by the top (mode) bit.
    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MFHI  = 4'b0111;
    localparam logic [3:0] MDU_MFLO  = 4'b1111;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_mul(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_mdu_class(input logic [3:0] op);
        return is_muldiv(op) || (op == MDU_MTHI) || (op == MDU_MTLO) ||
               (op == MDU_MFHI) || (op == MDU_MFLO);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the HI/LO pair for one op.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    logic                      signed_op;
    logic [2*WIDTH-1:0]        a_ext;
    logic [2*WIDTH-1:0]        b_ext;
    logic [2*WIDTH-1:0]        product;
    logic signed [2*WIDTH-1:0] divisor;

    // Zero-extended operands are non-negative at double width, so one signed
    // divider serves both DIV and DIVU, and most-negative / -1 cannot overflow.
    always_comb begin
        signed_op   = (op == MDU_MULT) || (op == MDU_DIV);
        a_ext       = signed_op ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        b_ext       = signed_op ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        div_by_zero = ((op == MDU_DIV) || (op == MDU_DIVU)) && (b == '0);
        divisor     = (b == '0) ? (2*WIDTH)'(1) : $signed(b_ext);
        product     = a_ext * b_ext;
        hi          = '0;
        lo          = '0;
        case (op)
            MDU_MULT, MDU_MULTU: {hi, lo} = product;
            MDU_DIV, MDU_DIVU: begin
                lo = WIDTH'($signed(a_ext) / divisor);
                hi = WIDTH'($signed(a_ext) % divisor);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu_multicycle.sv
// E-stage multiply/divide unit: owns HI/LO, models mul/div latency with a
// counter and reports busy/stall to the hazard unit.
module e_mdu_multicycle
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       E_MDUOp,
    input  logic             E_Start,
    input  logic             E_Flush,
    input  logic [WIDTH-1:0] E_A,
    input  logic [WIDTH-1:0] E_B,
    output logic             E_Busy,
    output logic             E_Stall,
    output logic [WIDTH-1:0] E_HI,
    output logic [WIDTH-1:0] E_LO,
    output logic [WIDTH-1:0] E_MDUResult
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] MULT_LAST = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);

    mdu_state_t       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] hi_stage, lo_stage, hi_q, lo_q;
    logic             dbz_stage;
    logic [WIDTH-1:0] arith_hi, arith_lo;
    logic             arith_dbz;
    logic             busy, accept, last_count, update_hilo, idle_write;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op          (E_MDUOp),
        .a           (E_A),
        .b           (E_B),
        .hi          (arith_hi),
        .lo          (arith_lo),
        .div_by_zero (arith_dbz)
    );

    assign busy       = (state_q == BUSY);
    assign accept     = E_Start && !busy && !E_Flush && is_muldiv(E_MDUOp);
    assign idle_write = E_Start && !busy && !E_Flush;
    assign last_count = (count_q == (is_mul(op_q) ? MULT_LAST : DIV_LAST));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // A flush in BUSY wins over the final count, so a cancelled op never lands.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        update_hilo = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    count_d = '0;
                end
            end
            BUSY: begin
                if (E_Flush) begin
                    state_d = IDLE;
                    count_d = '0;
                end else if (last_count) begin
                    state_d     = IDLE;
                    count_d     = '0;
                    update_hilo = !dbz_stage;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= MDU_NONE;
            hi_stage  <= '0;
            lo_stage  <= '0;
            dbz_stage <= 1'b0;
        end else if (accept) begin
            op_q      <= E_MDUOp;
            hi_stage  <= arith_hi;
            lo_stage  <= arith_lo;
            dbz_stage <= arith_dbz;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (update_hilo) begin
            hi_q <= hi_stage;
            lo_q <= lo_stage;
        end else if (idle_write && (E_MDUOp == MDU_MTHI)) begin
            hi_q <= E_A;
        end else if (idle_write && (E_MDUOp == MDU_MTLO)) begin
            lo_q <= E_A;
        end
    end

    always_comb begin
        case (E_MDUOp)
            MDU_MFHI: E_MDUResult = hi_q;
            MDU_MFLO: E_MDUResult = lo_q;
            default:  E_MDUResult = '0;
        endcase
    end

    assign E_Busy  = busy;
    assign E_Stall = busy || (E_Start && (is_muldiv(E_MDUOp) || (is_mdu_class(E_MDUOp) && busy)));
    assign E_HI    = hi_q;
    assign E_LO    = lo_q;

endmodule
